// File: rtl/xbus_if.sv
// xbus initiator/responder signal bundle used between xbus_dma, the arbiter and responders.
// master = initiator side (drives request and bus cycle), slave = arbiter/decoder side.
interface xbus_if #(
   parameter int XADDRW = 32,
   parameter int XDATAW = 32
);
   localparam int XBYTEC = XDATAW / 8;

   logic              req;
   logic              gnt;
   logic              as;
   logic              we;
   logic [XBYTEC-1:0] be;
   logic [XADDRW-1:0] addr;
   logic [XDATAW-1:0] wdata;
   logic [XDATAW-1:0] rdata;

   modport master (output req, as, we, be, addr, wdata, input gnt, rdata);
   modport slave  (input req, as, we, be, addr, wdata, output gnt, rdata);
endinterface

// File: rtl/xbus_dma.sv
// Word-copy DMA initiator on xbus: request bus, then read-then-write each word, release, pulse done.
// Optional XBUS_DMA_FILL_EN adds a fill mode that writes a constant word without reading.
module xbus_dma #(
   parameter int CNTW   = 16,
   parameter int RD_LAT = 1,
   parameter int XADDRW = 32,
   parameter int XDATAW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [XADDRW-1:0] src_addr,
   input  logic [XADDRW-1:0] dst_addr,
   input  logic [CNTW-1:0]   word_cnt,
`ifdef XBUS_DMA_FILL_EN
   input  logic              fill,
   input  logic [XDATAW-1:0] fill_data,
`endif
   output logic              busy,
   output logic              done,
   xbus_if.master            xbus
);
   localparam int XBYTEC = XDATAW / 8;
   localparam int LATW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LATW-1:0]   LAT_LAST = LATW'(RD_LAT - 1);
   localparam logic [XADDRW-1:0] ALIGN    = ~XADDRW'(3);
   localparam logic [XADDRW-1:0] STEP     = XADDRW'(4);
   localparam logic [XBYTEC-1:0] BE_ALL   = '1;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RA, S_RW, S_WR, S_DONE} state_t;

   state_t            r_state;
   logic [XADDRW-1:0] r_src, r_dst;
   logic [CNTW-1:0]   r_cnt;
   logic [LATW-1:0]   r_lat;
   logic              r_req, r_as, r_we, r_busy, r_done;
   logic [XBYTEC-1:0] r_be;
   logic [XADDRW-1:0] r_addr;
   logic [XDATAW-1:0] r_wdata;
   logic              w_fill;
   logic [XDATAW-1:0] w_fill_data;

`ifdef XBUS_DMA_FILL_EN
   logic              r_fill;
   logic [XDATAW-1:0] r_fill_data;

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && start) begin
         r_fill      <= fill;
         r_fill_data <= fill_data;
      end
   end

   assign w_fill      = r_fill;
   assign w_fill_data = r_fill_data;
`else
   assign w_fill      = 1'b0;
   assign w_fill_data = '0;
`endif

   // Outputs are registered: each branch loads the values the next state must present.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_as    <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src <= src_addr & ALIGN;
                  r_dst <= dst_addr & ALIGN;
                  r_cnt <= word_cnt;
                  if (word_cnt != '0) begin
                     r_state <= S_REQ;
                     r_req   <= 1'b1;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (xbus.gnt) begin
                  r_as <= 1'b1;
                  r_be <= BE_ALL;
                  if (w_fill) begin
                     r_state <= S_WR;
                     r_we    <= 1'b1;
                     r_addr  <= r_dst;
                     r_wdata <= w_fill_data;
                  end else begin
                     r_state <= S_RA;
                     r_we    <= 1'b0;
                     r_addr  <= r_src;
                  end
               end
            end
            S_RA: begin
               r_state <= S_RW;
               r_lat   <= '0;
            end
            // Strobe and read address stay up so the decoder keeps the responder selected.
            S_RW: begin
               if (r_lat == LAT_LAST) begin
                  r_state <= S_WR;
                  r_we    <= 1'b1;
                  r_addr  <= r_dst;
                  r_wdata <= xbus.rdata;
               end else begin
                  r_lat <= r_lat + LATW'(1);
               end
            end
            S_WR: begin
               r_src <= r_src + STEP;
               r_dst <= r_dst + STEP;
               r_cnt <= r_cnt - CNTW'(1);
               if (r_cnt != CNTW'(1)) begin
                  if (w_fill) begin
                     r_addr <= r_dst + STEP;
                  end else begin
                     r_state <= S_RA;
                     r_we    <= 1'b0;
                     r_addr  <= r_src + STEP;
                     r_wdata <= '0;
                  end
               end else begin
                  r_state <= S_DONE;
                  r_req   <= 1'b0;
                  r_as    <= 1'b0;
                  r_we    <= 1'b0;
                  r_be    <= '0;
                  r_addr  <= '0;
                  r_wdata <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign xbus.req   = r_req;
   assign xbus.as    = r_as;
   assign xbus.we    = r_we;
   assign xbus.be    = r_be;
   assign xbus.addr  = r_addr;
   assign xbus.wdata = r_wdata;
endmodule
